dmem_responder: RTL and testbench

//   Memory-side responder for the CPU data-memory port. Serves load, store, push and pop

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 17 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// default bus widths and the address range check.
package dmem_responder_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Addresses are widened to 32 bits so any AW up to 32 compares cleanly.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline's data-memory port and the responder.
interface dmem_responder_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          busy;
    logic          err;

    modport master (output req, we, addr, wdata, input rdata, ack, busy, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DW word storage: synchronous write, registered read, no reset so the
// array maps onto block RAM.
module dmem_array #(
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_reg [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES wait
// states, then returns a one-cycle ack with read data or an out-of-range error.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int              IW        = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]    addr_reg;
    logic             we_reg;
    logic [DW-1:0]    wdata_reg;
    logic             rdata_valid_reg;

    logic             accept;
    logic             access;
    logic [AW-1:0]    acc_addr;
    logic             acc_we;
    logic [DW-1:0]    acc_wdata;
    logic             acc_in_range;
    logic             ram_we;
    logic             ram_re;
    logic [DW-1:0]    ram_rdata;
    logic             ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // access marks the edge that enters RESP: the single point where the array is touched.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        access     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    accept   = 1'b1;
                    cnt_next = WAIT_INIT;
                    if (WAIT_INIT == '0) begin
                        state_next = ST_RESP;
                        access     = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = ST_RESP;
                    access     = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
        end else if (accept) begin
            addr_reg  <= bus.addr;
            we_reg    <= bus.we;
            wdata_reg <= bus.wdata;
        end
    end

    // With zero wait states the access coincides with acceptance, so the live bus is used.
    assign acc_addr     = (state_reg == ST_IDLE) ? bus.addr  : addr_reg;
    assign acc_we       = (state_reg == ST_IDLE) ? bus.we    : we_reg;
    assign acc_wdata    = (state_reg == ST_IDLE) ? bus.wdata : wdata_reg;
    assign acc_in_range = addr_in_range(32'(acc_addr), DEPTH);

    assign ram_we = access && !rst && acc_we && acc_in_range;
    assign ram_re = access && !rst && !acc_we && acc_in_range;

    dmem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (acc_addr[IW-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Out-of-range responses zero rdata; in-range writes leave the last read visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_valid_reg <= 1'b0;
        end else if (access) begin
            if (!acc_in_range) begin
                rdata_valid_reg <= 1'b0;
            end else if (!acc_we) begin
                rdata_valid_reg <= 1'b1;
            end
        end
    end

    assign ack       = (state_reg == ST_RESP);
    assign bus.ack   = ack;
    assign bus.busy  = (state_reg != ST_IDLE);
    assign bus.err   = ack && !addr_in_range(32'(addr_reg), DEPTH);
    assign bus.rdata = rdata_valid_reg ? ram_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (1, 3 and 0 wait states)
// checked through a scoreboard of expected responses.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_v   [3];
    logic        we_v    [3];
    logic [15:0] addr_v  [3];
    logic [15:0] wdata_v [3];
    logic [15:0] rdata_v [3];
    logic        ack_v   [3];
    logic        busy_v  [3];
    logic        err_v   [3];

    dmem_responder_if #(.DW(16), .AW(16)) bus0 ();
    dmem_responder_if #(.DW(16), .AW(16)) bus1 ();
    dmem_responder_if #(.DW(16), .AW(16)) bus2 ();

    assign bus0.req = req_v[0];  assign bus0.we = we_v[0];
    assign bus0.addr = addr_v[0]; assign bus0.wdata = wdata_v[0];
    assign rdata_v[0] = bus0.rdata; assign ack_v[0] = bus0.ack;
    assign busy_v[0] = bus0.busy;   assign err_v[0] = bus0.err;

    assign bus1.req = req_v[1];  assign bus1.we = we_v[1];
    assign bus1.addr = addr_v[1]; assign bus1.wdata = wdata_v[1];
    assign rdata_v[1] = bus1.rdata; assign ack_v[1] = bus1.ack;
    assign busy_v[1] = bus1.busy;   assign err_v[1] = bus1.err;

    assign bus2.req = req_v[2];  assign bus2.we = we_v[2];
    assign bus2.addr = addr_v[2]; assign bus2.wdata = wdata_v[2];
    assign rdata_v[2] = bus2.rdata; assign ack_v[2] = bus2.ack;
    assign busy_v[2] = bus2.busy;   assign err_v[2] = bus2.err;

    dmem_responder #(.DW(16), .AW(16), .DEPTH(256), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.DW(16), .AW(16), .DEPTH(256), .WAIT_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_responder #(.DW(16), .AW(16), .DEPTH(256), .WAIT_CYCLES(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        int          d;
        logic [15:0] rdata;
        logic        err;
        bit          chk_rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic idle_check(input int d, input string tag);
        check({tag, "_ack"},  32'(ack_v[d]),  32'd0);
        check({tag, "_busy"}, 32'(busy_v[d]), 32'd0);
        check({tag, "_err"},  32'(err_v[d]),  32'd0);
    endtask

    // pre: edges from raising req to the acceptance edge (2 when the DUT is still in RESP).
    // Latency counts the acceptance edge itself, so ack appears WAIT+1 edges in.
    task automatic issue(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] er, input bit ee, input int pre, input bit drop,
                         input bit keep);
        exp_t  e;
        exp_t  got;
        int    edges;
        int    lat;
        string tag;
        tag = $sformatf("d%0d_%s_a%0d", d, w ? "wr" : "rd", a);
        e.d = d; e.rdata = er; e.err = ee; e.chk_rdata = !w || ee; e.lat = wait_of(d) + 1;
        sb.push_back(e);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (busy_v[d] !== 1'b1) check({tag, "_gap_ack"}, 32'(ack_v[d]), 32'd0);
        end while (busy_v[d] !== 1'b1 && edges < 20);
        check({tag, "_accept_edges"}, edges, pre);
        if (drop) begin
            req_v[d] = 1'b0; addr_v[d] = a + 16'd5; we_v[d] = !w; wdata_v[d] = ~wd;
        end
        lat = 1;
        while (ack_v[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sb.pop_front();
        check({tag, "_latency"}, lat, got.lat);
        check({tag, "_err"}, 32'(err_v[got.d]), 32'(got.err));
        check({tag, "_busy_at_ack"}, 32'(busy_v[got.d]), 32'd1);
        if (got.chk_rdata) check({tag, "_rdata"}, 32'(rdata_v[got.d]), 32'(got.rdata));
        $display("txn %s lat=%0d err=%0b rdata=0x%04h", tag, lat, err_v[d], rdata_v[d]);
        if (!keep) begin
            req_v[d] = 1'b0;
            @(posedge clk); #1;
            idle_check(d, {tag, "_after"});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 1'b1; we_v[d] = 1'b1; addr_v[d] = 16'd23; wdata_v[d] = 16'hDEAD;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            idle_check(d, $sformatf("reset_d%0d", d));
            check($sformatf("reset_d%0d_rdata", d), 32'(rdata_v[d]), 32'd0);
        end
        for (int d = 0; d < 3; d++) req_v[d] = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // One wait state: write then read, inputs scrambled during WAIT on the read.
        issue(0, 1'b1, 16'd20, 16'h0007, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
        issue(0, 1'b0, 16'd20, 16'h0000, 16'h0007, 1'b0, 1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("hold_rdata", 32'(rdata_v[0]), 32'h0007);

        // Back-to-back pushes with req held high.
        issue(0, 1'b1, 16'd19, 16'd5, 16'h0000, 1'b0, 1, 1'b0, 1'b1);
        issue(0, 1'b1, 16'd18, 16'd6, 16'h0000, 1'b0, 2, 1'b0, 1'b1);
        issue(0, 1'b1, 16'd17, 16'd9, 16'h0000, 1'b0, 2, 1'b0, 1'b0);
        issue(0, 1'b0, 16'd19, 16'd0, 16'd5, 1'b0, 1, 1'b0, 1'b0);
        issue(0, 1'b0, 16'd18, 16'd0, 16'd6, 1'b0, 1, 1'b0, 1'b0);
        issue(0, 1'b0, 16'd17, 16'd0, 16'd9, 1'b0, 1, 1'b0, 1'b0);

        // Out of range: no aliasing onto 300 mod 256 = 44.
        issue(0, 1'b1, 16'd44,  16'h0044, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
        issue(0, 1'b1, 16'd300, 16'hBEEF, 16'h0000, 1'b1, 1, 1'b0, 1'b0);
        issue(0, 1'b0, 16'd44,  16'h0000, 16'h0044, 1'b0, 1, 1'b0, 1'b0);
        issue(0, 1'b0, 16'd300, 16'h0000, 16'h0000, 1'b1, 1, 1'b0, 1'b0);

        // Reset during WAIT aborts the pending write.
        issue(1, 1'b1, 16'd21, 16'h00AA, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'd21; wdata_v[1] = 16'h1234;
        @(posedge clk); #1;
        check("abort_busy_after_accept", 32'(busy_v[1]), 32'd1);
        @(posedge clk); #1;
        check("abort_ack_in_wait", 32'(ack_v[1]), 32'd0);
        rst = 1'b1; req_v[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check(1, "abort_after_rst");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("abort_no_ack_%0d", i), 32'(ack_v[1]), 32'd0);
        end
        issue(1, 1'b0, 16'd21, 16'h0000, 16'h00AA, 1'b0, 1, 1'b0, 1'b0);

        // Zero wait states, req dropped and addr changed right after acceptance.
        issue(2, 1'b1, 16'd22, 16'h5A5A, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
        issue(2, 1'b1, 16'd27, 16'h0F0F, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
        issue(2, 1'b0, 16'd22, 16'h0000, 16'h5A5A, 1'b0, 1, 1'b1, 1'b0);
        issue(2, 1'b0, 16'd27, 16'h0000, 16'h0F0F, 1'b0, 1, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
